key_event: RTL and testbench

KEY_EVENT -- requirements
Module: key_event

---
 rtl/key_pkg.sv | 22 ++
 rtl/key_event.sv | 126 ++++++++++++
 tb/tb_key_event.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/key_pkg.sv
`default_nettype none
// ---- key_pkg : shared state encoding and default timing constants for key_event ----
// Rev 1.0
package key_pkg;

  localparam int LONG_CNT_DEFAULT = 50_000_000;
  localparam int DBL_CNT_DEFAULT  = 15_000_000;

  typedef logic [2:0] key_state_t;

  localparam key_state_t ST_IDLE           = 3'd0;
  localparam key_state_t ST_PRESSED        = 3'd1;
  localparam key_state_t ST_LONG_HELD      = 3'd2;
  localparam key_state_t ST_WAIT_SECOND    = 3'd3;
  localparam key_state_t ST_SECOND_PRESSED = 3'd4;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_event.sv
`default_nettype none
// ---- key_event : press/release/short/long/double-click classifier for a debounced key ----
// Rev 1.0. Double-click detection is compiled in by defining KEY_EVENT_DBLCLICK_EN.
module key_event
  import key_pkg::*;
#(
  parameter int   LONG_CNT    = LONG_CNT_DEFAULT,
  parameter int   DBL_CNT     = DBL_CNT_DEFAULT,
  parameter logic PRESS_LEVEL = 1'b0
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic key_status,
  output logic evt_press,
  output logic evt_release,
  output logic evt_short,
  output logic evt_long,
  output logic evt_double,
  output logic key_busy
);

  localparam int CNT_W = $clog2(max_int(LONG_CNT, DBL_CNT)) + 1;
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);
`ifdef KEY_EVENT_DBLCLICK_EN
  localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_CNT - 1);
`endif

  logic             key_d;
  logic             armed;
  key_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             press_edge;
  logic             release_edge;

  // A key held through reset must be seen released before its next press counts.
  assign press_edge   = armed && (key_d != PRESS_LEVEL) && (key_status == PRESS_LEVEL);
  assign release_edge = (key_d == PRESS_LEVEL) && (key_status != PRESS_LEVEL);
  assign cnt_inc      = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
  assign key_busy     = (state != ST_IDLE);

`ifndef KEY_EVENT_DBLCLICK_EN
  assign evt_double = 1'b0;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      key_d       <= ~PRESS_LEVEL;
      armed       <= 1'b0;
      state       <= ST_IDLE;
      cnt         <= '0;
      evt_press   <= 1'b0;
      evt_release <= 1'b0;
      evt_short   <= 1'b0;
      evt_long    <= 1'b0;
`ifdef KEY_EVENT_DBLCLICK_EN
      evt_double  <= 1'b0;
`endif
    end else begin
      key_d       <= key_status;
      if (key_status != PRESS_LEVEL) armed <= 1'b1;
      evt_press   <= press_edge;
      evt_release <= release_edge;
      evt_short   <= 1'b0;
      evt_long    <= 1'b0;
`ifdef KEY_EVENT_DBLCLICK_EN
      evt_double  <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (press_edge) begin
            state <= ST_PRESSED;
            cnt   <= '0;
          end
        end
        // Release is tested before the terminal count so it wins a tie.
        ST_PRESSED: begin
          if (release_edge) begin
`ifdef KEY_EVENT_DBLCLICK_EN
            state <= ST_WAIT_SECOND;
            cnt   <= '0;
`else
            state     <= ST_IDLE;
            evt_short <= 1'b1;
`endif
          end else if (cnt == LONG_LAST) begin
            state    <= ST_LONG_HELD;
            evt_long <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end
        ST_LONG_HELD: begin
          if (release_edge) state <= ST_IDLE;
        end
`ifdef KEY_EVENT_DBLCLICK_EN
        ST_WAIT_SECOND: begin
          if (press_edge) begin
            state <= ST_SECOND_PRESSED;
            cnt   <= '0;
          end else if (cnt == DBL_LAST) begin
            state     <= ST_IDLE;
            evt_short <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end
        ST_SECOND_PRESSED: begin
          if (release_edge) begin
            state      <= ST_IDLE;
            evt_double <= 1'b1;
          end else if (cnt == LONG_LAST) begin
            state    <= ST_LONG_HELD;
            evt_long <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_key_event.sv
`default_nettype none
// ---- tb_key_event : scoreboard bench for key_event (LONG_CNT=100, DBL_CNT=40) ----
// Rev 1.0
module tb_key_event;

  localparam int LONG_CNT = 100;
  localparam int DBL_CNT  = 40;

  localparam logic [4:0] EV_PRESS = 5'b10000;
  localparam logic [4:0] EV_REL   = 5'b01000;
  localparam logic [4:0] EV_SHORT = 5'b00100;
  localparam logic [4:0] EV_LONG  = 5'b00010;
  localparam logic [4:0] EV_DBL   = 5'b00001;

  typedef struct {
    int         cyc;
    logic [4:0] ev;
  } exp_t;

  logic sys_clk    = 1'b0;
  logic sys_rst    = 1'b0;
  logic key_status = 1'b0;
  logic evt_press, evt_release, evt_short, evt_long, evt_double, key_busy;

  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t head;
  logic [4:0] obs;

  key_event #(
    .LONG_CNT   (LONG_CNT),
    .DBL_CNT    (DBL_CNT),
    .PRESS_LEVEL(1'b0)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .key_status (key_status),
    .evt_press  (evt_press),
    .evt_release(evt_release),
    .evt_short  (evt_short),
    .evt_long   (evt_long),
    .evt_double (evt_double),
    .key_busy   (key_busy)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Every event cycle pops one expectation; timing and event mix must both match.
  always @(negedge sys_clk) begin
    if (sys_rst) begin
      obs = {evt_press, evt_release, evt_short, evt_long, evt_double};
      if (obs != 5'b0) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event cyc=%0d got=%b required=none", cyc, obs);
        end else begin
          head = sb.pop_front();
          if (head.cyc != cyc || head.ev !== obs) begin
            errors++;
            $display("FAIL event got cyc=%0d ev=%b required cyc=%0d ev=%b",
                     cyc, obs, head.cyc, head.ev);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic push(input int c, input logic [4:0] ev);
    exp_t e;
    e.cyc = c;
    e.ev  = ev;
    sb.push_back(e);
  endtask

  task automatic expect_drained(input string name);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_missing got pending=%0d required=0 next_cyc=%0d", name, sb.size(), sb[0].cyc);
      sb.delete();
    end
    checks++;
    if (key_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_busy_idle got=%b required=0", name, key_busy);
    end
  endtask

  // Drives a press of 'hold' cycles; expectations come from the timing rules.
  task automatic do_press(input int hold);
    int p, r;
    p = cyc;
    r = p + hold;
    push(p + 1, EV_PRESS);
    if (hold > LONG_CNT) begin
      push(p + LONG_CNT + 1, EV_LONG);
      push(r + 1, EV_REL);
    end else begin
`ifdef KEY_EVENT_DBLCLICK_EN
      push(r + 1, EV_REL);
      push(r + DBL_CNT + 1, EV_SHORT);
`else
      push(r + 1, EV_REL | EV_SHORT);
`endif
    end
    key_status = 1'b0;
    tick(hold);
    key_status = 1'b1;
    tick(DBL_CNT + 10);
  endtask

  task automatic test_reset;
    int c;
    sys_rst    = 1'b0;
    key_status = 1'b0;
    tick(3);
    checks++;
    if ({evt_press, evt_release, evt_short, evt_long, evt_double, key_busy} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs got=%b required=000000",
               {evt_press, evt_release, evt_short, evt_long, evt_double, key_busy});
    end
    sys_rst = 1'b1;
    tick(8);
    checks++;
    if (key_busy !== 1'b0) begin
      errors++;
      $display("FAIL held_through_reset_busy got=%b required=0", key_busy);
    end
    c = cyc;
    push(c + 1, EV_REL);
    key_status = 1'b1;
    tick(3);
    do_press(5);
    expect_drained("reset");
  endtask

  task automatic test_short;
    do_press(20);
    do_press(1);
    expect_drained("short");
  endtask

  task automatic test_long;
    do_press(150);
    expect_drained("long");
  endtask

  task automatic test_boundary;
    do_press(LONG_CNT);
    do_press(LONG_CNT + 1);
    do_press(LONG_CNT - 1);
    expect_drained("boundary");
  endtask

`ifdef KEY_EVENT_DBLCLICK_EN
  task automatic do_double(input int h1, input int gap, input int h2);
    int p, r, s, t;
    p = cyc;
    r = p + h1;
    s = r + gap;
    t = s + h2;
    push(p + 1, EV_PRESS);
    push(r + 1, EV_REL);
    if (gap <= DBL_CNT) begin
      push(s + 1, EV_PRESS);
      push(t + 1, EV_REL | EV_DBL);
    end else begin
      push(r + DBL_CNT + 1, EV_SHORT);
      push(s + 1, EV_PRESS);
      push(t + 1, EV_REL);
      push(t + DBL_CNT + 1, EV_SHORT);
    end
    key_status = 1'b0;
    tick(h1);
    key_status = 1'b1;
    tick(gap / 2);
    checks++;
    if (key_busy !== 1'b1) begin
      errors++;
      $display("FAIL wait_second_busy got=%b required=1", key_busy);
    end
    tick(gap - gap / 2);
    key_status = 1'b0;
    tick(h2);
    key_status = 1'b1;
    tick(DBL_CNT + 10);
  endtask

  task automatic test_double;
    do_double(10, 20, 10);
    do_double(10, DBL_CNT, 10);
    do_double(10, DBL_CNT + 1, 10);
    do_press(10);
    expect_drained("double");
  endtask
`endif

  task automatic test_reset_mid;
    int p;
    p = cyc;
    push(p + 1, EV_PRESS);
    key_status = 1'b0;
    tick(LONG_CNT + 1);
    checks++;
    if (evt_long !== 1'b1 || key_busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_long got long=%b busy=%b required long=1 busy=1", evt_long, key_busy);
    end
    #1 sys_rst = 1'b0;
    #1;
    checks++;
    if ({evt_press, evt_release, evt_short, evt_long, evt_double, key_busy} !== 6'b0) begin
      errors++;
      $display("FAIL async_reset_outputs got=%b required=000000",
               {evt_press, evt_release, evt_short, evt_long, evt_double, key_busy});
    end
    tick(2);
    key_status = 1'b1;
    tick(2);
    sys_rst = 1'b1;
    tick(5);
    expect_drained("reset_mid");
    do_press(30);
    expect_drained("after_reset");
  endtask

  initial begin
    test_reset();
    test_short();
    test_long();
    test_boundary();
`ifdef KEY_EVENT_DBLCLICK_EN
    test_double();
`endif
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
